// File: rtl/axis_write_ctrl.sv
// AXI write-stream sequencer: takes a start address and stream length, hands the
// length to the write data channel, issues AW bursts and collects every B response.
module axis_write_ctrl #(
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_LEN_WIDTH  = 8,
    parameter int AXI_DATA_WIDTH = 64,
    parameter int CFG_DWIDTH     = 32,
    parameter int RATIO_SHIFT    = 1,
    parameter int OUT_AWIDTH     = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [AXI_ADDR_WIDTH-1:0] cfg_address,
    input  logic [CFG_DWIDTH-1:0]     cfg_length,
    input  logic                      cfg_valid,
    output logic                      cfg_ready,
    output logic [CFG_DWIDTH-1:0]     wr_length,
    output logic                      wr_valid,
    input  logic                      wr_ready,
    output logic [AXI_ADDR_WIDTH-1:0] axi_awaddr,
    output logic [AXI_LEN_WIDTH-1:0]  axi_awlen,
    output logic                      axi_awvalid,
    input  logic                      axi_awready,
    input  logic [1:0]                axi_bresp,
    input  logic                      axi_bvalid,
    output logic                      axi_bready,
    output logic                      done,
    output logic                      error
);

    localparam int BYTE_SHIFT = $clog2(AXI_DATA_WIDTH / 8);
    localparam int OUT_MAX    = 1 << OUT_AWIDTH;

    typedef enum logic [4:0] {
        IDLE   = 5'b00001,
        CONFIG = 5'b00010,
        BURST  = 5'b00100,
        DRAIN  = 5'b01000,
        DONE   = 5'b10000
    } state_t;

    state_t                    state_q, state_d;
    logic [AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [CFG_DWIDTH-1:0]     wr_length_q, wr_length_d;
    logic [CFG_DWIDTH-1:0]     beats_left_q, beats_left_d;
    logic [OUT_AWIDTH:0]       out_q, out_d;
    logic                      cfg_ready_q, cfg_ready_d;
    logic                      wr_valid_q, wr_valid_d;
    logic                      awvalid_q, awvalid_d;
    logic                      bready_q, bready_d;
    logic                      done_q, done_d;
    logic                      error_q, error_d;

    logic                      full_burst;
    logic [AXI_LEN_WIDTH-1:0]  awlen;
    logic [AXI_LEN_WIDTH:0]    burst_beats;
    logic                      aw_hs;
    logic                      b_hs;

    // Burst length is derived from the remaining beat count, so it only moves on an AW handshake.
    assign full_burst  = (beats_left_q >> AXI_LEN_WIDTH) != '0;
    assign awlen       = full_burst ? '1 : (beats_left_q[AXI_LEN_WIDTH-1:0] - AXI_LEN_WIDTH'(1));
    assign burst_beats = {1'b0, awlen} + (AXI_LEN_WIDTH + 1)'(1);
    assign aw_hs       = awvalid_q & axi_awready;
    assign b_hs        = axi_bvalid & bready_q;

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        wr_length_d  = wr_length_q;
        beats_left_d = beats_left_q;
        out_d        = out_q;
        error_d      = error_q;

        case ({aw_hs, b_hs})
            2'b10:   out_d = out_q + (OUT_AWIDTH + 1)'(1);
            2'b01:   out_d = out_q - (OUT_AWIDTH + 1)'(1);
            default: out_d = out_q;
        endcase

        if (b_hs && (axi_bresp != 2'b00)) begin
            error_d = 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                if (cfg_valid) begin
                    addr_d       = cfg_address;
                    wr_length_d  = cfg_length;
                    beats_left_d = cfg_length >> RATIO_SHIFT;
                    out_d        = '0;
                    error_d      = 1'b0;
                    state_d      = (cfg_length == '0) ? DONE : CONFIG;
                end
            end
            CONFIG: begin
                if (wr_valid_q && wr_ready) begin
                    state_d = BURST;
                end
            end
            BURST: begin
                if (aw_hs) begin
                    addr_d       = addr_q + (AXI_ADDR_WIDTH'(burst_beats) << BYTE_SHIFT);
                    beats_left_d = beats_left_q - CFG_DWIDTH'(burst_beats);
                    if (beats_left_d == '0) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (out_q == '0) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs are registered from the next state so they line up with it.
        cfg_ready_d = (state_d == IDLE);
        wr_valid_d  = (state_d == CONFIG);
        awvalid_d   = (state_d == BURST) && (beats_left_d != '0) &&
                      (out_d < (OUT_AWIDTH + 1)'(OUT_MAX));
        bready_d    = (state_d == BURST) || (state_d == DRAIN);
        done_d      = (state_d == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            wr_length_q  <= '0;
            beats_left_q <= '0;
            out_q        <= '0;
            cfg_ready_q  <= 1'b1;
            wr_valid_q   <= 1'b0;
            awvalid_q    <= 1'b0;
            bready_q     <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            wr_length_q  <= wr_length_d;
            beats_left_q <= beats_left_d;
            out_q        <= out_d;
            cfg_ready_q  <= cfg_ready_d;
            wr_valid_q   <= wr_valid_d;
            awvalid_q    <= awvalid_d;
            bready_q     <= bready_d;
            done_q       <= done_d;
            error_q      <= error_d;
        end
    end

    assign cfg_ready   = cfg_ready_q;
    assign wr_length   = wr_length_q;
    assign wr_valid    = wr_valid_q;
    assign axi_awaddr  = addr_q;
    assign axi_awlen   = awlen;
    assign axi_awvalid = awvalid_q;
    assign axi_bready  = bready_q;
    assign done        = done_q;
    assign error       = error_q;

endmodule

// File: tb/tb_axis_write_ctrl.sv
// Randomized scoreboard bench for axis_write_ctrl: expected wr/AW/done traffic is queued
// when a stream is configured and popped by an independent monitor.
module tb_axis_write_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] cfg_address = '0;
    logic [31:0] cfg_length = '0;
    logic        cfg_valid = 1'b0;
    logic        cfg_ready;
    logic [31:0] wr_length;
    logic        wr_valid;
    logic        wr_ready = 1'b0;
    logic [31:0] axi_awaddr;
    logic [7:0]  axi_awlen;
    logic        axi_awvalid;
    logic        axi_awready = 1'b0;
    logic [1:0]  axi_bresp = 2'b00;
    logic        axi_bvalid = 1'b0;
    logic        axi_bready;
    logic        done;
    logic        error;

    axis_write_ctrl dut (
        .clk(clk), .rst(rst),
        .cfg_address(cfg_address), .cfg_length(cfg_length),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .wr_length(wr_length), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .axi_awaddr(axi_awaddr), .axi_awlen(axi_awlen),
        .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
        .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid), .axi_bready(axi_bready),
        .done(done), .error(error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  len;
    } aw_t;

    aw_t         aw_q[$];
    logic [31:0] wr_q[$];
    logic [1:0]  bresp_q[$];
    logic        err_q[$];

    int compared = 0;
    int mismatched = 0;
    int pending = 0;
    int model_out = 0;
    int done_count = 0;
    int issued = 0;
    int aw_seen = 0;
    int wr_seen = 0;
    int wr_valid_cycles = 0;
    bit hold_b = 1'b0;
    bit wr_block = 1'b0;
    bit aw_block = 1'b0;
    bit stall_prev = 1'b0;
    logic [31:0] stall_addr;
    logic [7:0]  stall_len;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Builds the expected traffic from the stream rules; err_idx >= 0 forces that burst's
    // response to SLVERR, -1 means all OKAY, -2 means random responses.
    task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] len, input int err_idx);
        int rem;
        int n;
        int idx;
        int tries;
        logic [31:0] a;
        logic [1:0] br;
        logic err;
        tries = 0;
        while (!cfg_ready && tries < 500) begin
            @(posedge clk); #1;
            tries++;
        end
        if (!cfg_ready) begin
            checkOutput("cfg_ready_timeout", 64'(cfg_ready), 64'd1);
            return;
        end
        rem = int'(len / 2);
        a = addr;
        idx = 0;
        err = 1'b0;
        if (len != 0) wr_q.push_back(len);
        while (rem > 0) begin
            n = (rem > 256) ? 256 : rem;
            aw_q.push_back('{addr: a, len: 8'(n - 1)});
            if (idx == err_idx) br = 2'b10;
            else if (err_idx == -2 && $urandom_range(0, 5) == 0) br = ($urandom_range(0, 1) == 0) ? 2'b10 : 2'b11;
            else br = 2'b00;
            bresp_q.push_back(br);
            err = err | (br != 2'b00);
            a = a + 32'(n * 8);
            rem = rem - n;
            idx++;
        end
        err_q.push_back(err);
        cfg_address = addr;
        cfg_length = len;
        cfg_valid = 1'b1;
        @(posedge clk); #1;
        cfg_valid = 1'b0;
        issued++;
        checkOutput("error_cleared_on_cfg", 64'(error), 64'd0);
    endtask

    task automatic waitDone(input int budget, output int cycles);
        cycles = 0;
        while (done_count < issued && cycles < budget) begin
            @(negedge clk); #1;
            cycles++;
        end
        if (done_count < issued) begin
            checkOutput("done_timeout", 64'(done_count), 64'(issued));
            done_count = issued;
        end
    endtask

    // Ready generators for the write data channel and AW channel.
    initial begin
        forever begin
            @(posedge clk); #1;
            wr_ready = wr_block ? 1'b0 : ($urandom_range(0, 3) != 0);
            axi_awready = aw_block ? 1'b0 : ($urandom_range(0, 2) != 0);
        end
    end

    // B responder: answers accepted bursts in order after a random delay.
    initial begin
        bit fire;
        forever begin
            @(negedge clk);
            fire = axi_bvalid && axi_bready;
            @(posedge clk); #1;
            if (rst) begin
                axi_bvalid = 1'b0;
                axi_bresp = 2'b00;
            end else begin
                if (fire) begin
                    axi_bvalid = 1'b0;
                    axi_bresp = 2'b00;
                    pending--;
                end
                if (!axi_bvalid && pending > 0 && !hold_b && bresp_q.size() > 0 &&
                    $urandom_range(0, 2) == 0) begin
                    axi_bvalid = 1'b1;
                    axi_bresp = bresp_q.pop_front();
                end
            end
        end
    end

    // Monitor: pops the scoreboard whenever the DUT presents a handshake or done.
    initial begin
        aw_t exp_aw;
        logic exp_err;
        bit aw_fire;
        bit b_fire;
        forever begin
            @(negedge clk);
            if (rst) begin
                stall_prev = 1'b0;
            end else begin
                if (wr_valid) wr_valid_cycles++;
                if (wr_valid && wr_ready) begin
                    wr_seen++;
                    if (wr_q.size() == 0) checkOutput("wr_unexpected", 64'(wr_length), 64'hdead);
                    else checkOutput("wr_length", 64'(wr_length), 64'(wr_q.pop_front()));
                end
                if (axi_awvalid && model_out >= 4)
                    checkOutput("aw_outstanding_limit", 64'(model_out), 64'd3);
                if (stall_prev) begin
                    checkOutput("aw_hold_valid", 64'(axi_awvalid), 64'd1);
                    checkOutput("aw_hold_addr", 64'(axi_awaddr), 64'(stall_addr));
                    checkOutput("aw_hold_len", 64'(axi_awlen), 64'(stall_len));
                end
                aw_fire = axi_awvalid && axi_awready;
                if (aw_fire) begin
                    aw_seen++;
                    pending++;
                    if (aw_q.size() == 0) begin
                        checkOutput("aw_unexpected", 64'(axi_awaddr), 64'hdead);
                    end else begin
                        exp_aw = aw_q.pop_front();
                        checkOutput("aw_addr", 64'(axi_awaddr), 64'(exp_aw.addr));
                        checkOutput("aw_len", 64'(axi_awlen), 64'(exp_aw.len));
                    end
                end
                stall_prev = axi_awvalid && !axi_awready;
                stall_addr = axi_awaddr;
                stall_len = axi_awlen;
                b_fire = axi_bvalid && axi_bready;
                model_out = model_out + (aw_fire ? 1 : 0) - (b_fire ? 1 : 0);
                if (done) begin
                    if (err_q.size() == 0) begin
                        checkOutput("done_unexpected", 64'(done), 64'd0);
                    end else begin
                        exp_err = err_q.pop_front();
                        checkOutput("error_at_done", 64'(error), 64'(exp_err));
                        checkOutput("done_queues_empty", 64'(aw_q.size() + wr_q.size()), 64'd0);
                    end
                    done_count++;
                end
            end
        end
    end

    initial begin
        #3_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int cyc;
        int base;
        int wbase;
        #12;
        checkOutput("reset_cfg_ready", 64'(cfg_ready), 64'd1);
        checkOutput("reset_wr_valid", 64'(wr_valid), 64'd0);
        checkOutput("reset_awvalid", 64'(axi_awvalid), 64'd0);
        checkOutput("reset_bready", 64'(axi_bready), 64'd0);
        checkOutput("reset_done", 64'(done), 64'd0);
        checkOutput("reset_error", 64'(error), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        $display("[TB] single burst");
        applyStimulus(32'h1000, 32'd8, -1);
        waitDone(500, cyc);
        checkOutput("single_error", 64'(error), 64'd0);

        $display("[TB] full and remainder bursts");
        applyStimulus(32'h0, 32'd1024, -1);
        waitDone(500, cyc);
        applyStimulus(32'h0, 32'd1026, -1);
        waitDone(500, cyc);

        $display("[TB] outstanding limit");
        hold_b = 1'b1;
        base = aw_seen;
        applyStimulus(32'h0, 32'd6144, -1);
        repeat (80) @(negedge clk);
        #1;
        checkOutput("aw_count_at_limit", 64'(aw_seen - base), 64'd4);
        checkOutput("awvalid_at_limit", 64'(axi_awvalid), 64'd0);
        hold_b = 1'b0;
        waitDone(3000, cyc);

        $display("[TB] error response");
        applyStimulus(32'h4000, 32'd1024, 1);
        waitDone(500, cyc);
        repeat (3) @(negedge clk);
        checkOutput("error_sticky", 64'(error), 64'd1);

        $display("[TB] zero length");
        base = aw_seen;
        wbase = wr_valid_cycles;
        applyStimulus(32'h2000, 32'd0, -1);
        waitDone(20, cyc);
        checkOutput("zero_done_latency_ok", 64'(cyc <= 2), 64'd1);
        checkOutput("zero_no_aw", 64'(aw_seen - base), 64'd0);
        checkOutput("zero_no_wr_valid", 64'(wr_valid_cycles - wbase), 64'd0);

        $display("[TB] wr_ready backpressure");
        wr_block = 1'b1;
        base = aw_seen;
        applyStimulus(32'h8000, 32'd64, -1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("wr_valid_held", 64'(wr_valid), 64'd1);
            checkOutput("no_aw_before_wr", 64'(axi_awvalid), 64'd0);
        end
        wr_block = 1'b0;
        waitDone(500, cyc);

        $display("[TB] awready backpressure");
        aw_block = 1'b1;
        applyStimulus(32'h10000, 32'd600, -1);
        cyc = 0;
        while (!axi_awvalid && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput("stall_awaddr", 64'(axi_awaddr), 64'h10000);
            checkOutput("stall_awlen", 64'(axi_awlen), 64'd255);
        end
        aw_block = 1'b0;
        waitDone(1000, cyc);

        $display("[TB] reset mid-burst");
        hold_b = 1'b1;
        applyStimulus(32'h0, 32'd6144, -1);
        repeat (10) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("rst_cfg_ready", 64'(cfg_ready), 64'd1);
        checkOutput("rst_wr_valid", 64'(wr_valid), 64'd0);
        checkOutput("rst_awvalid", 64'(axi_awvalid), 64'd0);
        checkOutput("rst_bready", 64'(axi_bready), 64'd0);
        checkOutput("rst_done", 64'(done), 64'd0);
        checkOutput("rst_error", 64'(error), 64'd0);
        aw_q.delete();
        wr_q.delete();
        bresp_q.delete();
        err_q.delete();
        @(posedge clk); #1;
        pending = 0;
        model_out = 0;
        done_count = issued;
        hold_b = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        $display("[TB] random streams");
        for (int s = 0; s < 12; s++) begin
            applyStimulus(32'($urandom_range(0, 63)) << 11, 32'($urandom_range(0, 1600)) * 2, -2);
            waitDone(4000, cyc);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
